shift_serdes: RTL

- Parametrised full-duplex shift engine. Successor to the fixed 8-bit serial-in/serial-out shift register.
- Accepts a parallel word over a valid/ready handshake and shifts it out on sout, one bit per enabled cycle.
- Captures sin into the vacated end on the same edges, so after WIDTH shifts the register holds the received word. That word is presented with a one-cycle valid pulse.
- Sits between a parallel datapath and a serial link (SPI-like or loopback test path).

---
 rtl/shift_serdes_pkg.sv | 15 +
 rtl/shift_serdes_if.sv | 42 ++++
 rtl/shift_serdes_bitcnt.sv | 42 ++++
 rtl/shift_serdes.sv | 109 ++++++++++
 4 files changed

// File: rtl/shift_serdes_pkg.sv
// Shared definitions for the shift_serdes serial shift engine:
// FSM state encoding and bit-order selection constants.
package shift_serdes_pkg;

    // Frame state: waiting for a word, or shifting one out/in.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit-order selection values for the MSB_FIRST parameter.
    localparam bit ORDER_MSB = 1'b1;
    localparam bit ORDER_LSB = 1'b0;

endpackage

// File: rtl/shift_serdes_if.sv
// Handshake, serial and receive-side signals of shift_serdes bundled
// into one interface. The master drives words and serial input.
// The slave is the shift engine itself.
interface shift_serdes_if #(
    parameter int WIDTH = 8
);

    logic             en;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             sin;
    logic             sout;
    logic             busy;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;

    modport master (
        output en,
        output tx_data,
        output tx_valid,
        output sin,
        input  tx_ready,
        input  sout,
        input  busy,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  en,
        input  tx_data,
        input  tx_valid,
        input  sin,
        output tx_ready,
        output sout,
        output busy,
        output rx_data,
        output rx_valid
    );

endinterface

// File: rtl/shift_serdes_bitcnt.sv
// Bit counter for one shift_serdes frame. It counts enabled shift
// edges and flags the last bit position of the frame. Clear takes
// priority over enable, so the frame-ending edge returns it to zero.
module shift_serdes_bitcnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance on enabled edges.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High while the current bit is the final one of the frame.
    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/shift_serdes.sv
// Full-duplex parametrised shift engine. It accepts a parallel word
// and shifts it out on sout. At the same time it captures sin into the
// vacated end. After WIDTH enabled edges the register holds the
// received word. That word is published on rx_data with a one-cycle
// rx_valid pulse.
module shift_serdes
    import shift_serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = ORDER_MSB
) (
    input logic           clk,
    input logic           rst,
    shift_serdes_if.slave bus
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] rx_data_q;
    logic [WIDTH-1:0] rx_data_d;
    logic             rx_valid_q;
    logic             rx_valid_d;

    logic             shift_en;
    logic             last_bit;
    logic             cnt_clear;
    logic [WIDTH-1:0] shifted;

    // A shift happens only inside a frame, on edges where en is high.
    assign shift_en  = (state_q == ST_SHIFT) && bus.en;
    // Counter rests at zero while idle and restarts after the final bit.
    assign cnt_clear = (state_q == ST_IDLE) || (shift_en && last_bit);

    shift_serdes_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (shift_en),
        .last   (last_bit)
    );

    // Register contents after one shift in the configured bit order.
    always_comb begin
        shifted = shreg_q;
        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], bus.sin};
        end else begin
            shifted = {bus.sin, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: IDLE loads a word, SHIFT moves one bit per
    // enabled edge, and the final bit publishes the received word.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.tx_valid) begin
                    shreg_d = bus.tx_data;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.en) begin
                    shreg_d = shifted;
                    if (last_bit) begin
                        rx_data_d  = shifted;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers. Reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.tx_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q == ST_SHIFT);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    // sout is forced low while idle so the link rests at zero.
    assign bus.sout     = (state_q == ST_SHIFT) ?
                          (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;

endmodule
